// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: SPI mode encoding, FSM states
// and the four standard CPOL/CPHA mode constants.
package spi_pkg;

  // Bit order matches the req_mode port: {CPOL, CPHA}.
  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD,
    DONE
  } spi_state_e;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage

// File: rtl/spi_edge_gen.sv
// SPI clock generator. Divides sclk_senddata into CLK_DIV-cycle half-periods.
// tick marks the last cycle of each half-period; lead_edge/trail_edge are
// one-cycle strobes in that cycle when the following clock edge toggles spi_sclk.
// While clear is high the counter is held at zero and spi_sclk follows park.
module spi_edge_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic sclk_senddata,
  input  logic rst,
  input  logic clear,
  input  logic toggle_en,
  input  logic park,
  output logic tick,
  output logic lead_edge,
  output logic trail_edge,
  output logic spi_sclk
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q;
  logic            sclk_q;

  assign tick       = !clear && (cnt_q == CntW'(CLK_DIV - 1));
  // Leading edge leaves the idle level, trailing edge returns to it.
  assign lead_edge  = tick && toggle_en && (sclk_q == park);
  assign trail_edge = tick && toggle_en && (sclk_q != park);
  assign spi_sclk   = sclk_q;

  // Half-period counter, free-running modulo CLK_DIV outside of clear.
  always_ff @(posedge sclk_senddata or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // SPI clock level: park while cleared, toggle on enabled half-period boundaries.
  always_ff @(posedge sclk_senddata or negedge rst) begin
    if (!rst) begin
      sclk_q <= 1'b0;
    end else if (clear) begin
      sclk_q <= park;
    end else if (tick && toggle_en) begin
      sclk_q <= ~sclk_q;
    end
  end

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: any word width, CPOL/CPHA per request, MSB/LSB first,
// NUM_CS one-hot active-low chip selects, valid/ready request, pulsed response.
// Build option: define SPI_LOOPBACK_EN to add the loopback input, which feeds
// the internal MOSI back as the sampled bit instead of the spi_miso pin.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NUM_CS  = 4,
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              sclk_senddata,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_data,
  input  logic [CS_W-1:0]   req_cs,
  input  logic [1:0]        req_mode,
  input  logic              req_lsb_first,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int unsigned HcW = $clog2(2 * DATA_W) + 1;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    for (int i = 0; i < DATA_W; i++) begin
      bit_rev[i] = v[DATA_W-1-i];
    end
  endfunction

  spi_state_e        state_q;
  spi_mode_t         mode_q, mode_d;
  logic              lsb_q;
  logic              err_q;
  logic [DATA_W-1:0] tx_q;
  logic [DATA_W-1:0] rx_q;
  logic [HcW-1:0]    half_q;
  logic              mosi_q;
  logic [NUM_CS-1:0] cs_n_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_err_q;

  logic              accept;
  logic              bad_cs;
  logic [DATA_W-1:0] ordered;
  logic              miso_bit;
  logic              last_half;
  logic              skip_shift;
  logic              toggle_en;
  logic              gen_clear;
  logic              tick;
  logic              lead_edge;
  logic              trail_edge;
  logic              sample;
  logic              drive;

  assign accept  = req_valid && req_ready_q;
  assign bad_cs  = 32'(req_cs) >= NUM_CS;
  // tx_q always shifts out of its MSB, so LSB-first words are reversed on load.
  assign ordered = req_lsb_first ? bit_rev(req_data) : req_data;

  // Mode only changes on a good accept so a rejected request never moves sclk.
  assign mode_d  = (accept && !bad_cs) ? spi_mode_t'(req_mode) : mode_q;

`ifdef SPI_LOOPBACK_EN
  assign miso_bit = loopback ? mosi_q : spi_miso;
`else
  assign miso_bit = spi_miso;
`endif

  assign last_half  = (half_q == HcW'(2 * DATA_W - 1));
  // The edge entering the final half-period is the last trailing edge.
  assign skip_shift = (half_q == HcW'(2 * DATA_W - 2));
  assign toggle_en  = (state_q == SETUP) || ((state_q == XFER) && !last_half);
  assign gen_clear  = (state_q == IDLE) || (state_q == DONE);

  assign sample = mode_q.cpha ? trail_edge : lead_edge;
  assign drive  = mode_q.cpha ? lead_edge : (trail_edge && !skip_shift);

  spi_edge_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_edge_gen (
    .sclk_senddata (sclk_senddata),
    .rst           (rst),
    .clear         (gen_clear),
    .toggle_en     (toggle_en),
    .park          (mode_d.cpol),
    .tick          (tick),
    .lead_edge     (lead_edge),
    .trail_edge    (trail_edge),
    .spi_sclk      (spi_sclk)
  );

  // Transfer FSM with shift/capture datapath and registered outputs.
  always_ff @(posedge sclk_senddata or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      mode_q      <= MODE0;
      lsb_q       <= 1'b0;
      err_q       <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      half_q      <= '0;
      mosi_q      <= 1'b0;
      cs_n_q      <= '1;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      mode_q      <= mode_d;
      if (sample) begin
        rx_q <= {rx_q[DATA_W-2:0], miso_bit};
      end
      if (drive) begin
        mosi_q <= tx_q[DATA_W-1];
        tx_q   <= tx_q << 1;
      end
      unique case (state_q)
        IDLE: begin
          req_ready_q <= 1'b1;
          if (accept) begin
            req_ready_q <= 1'b0;
            lsb_q       <= req_lsb_first;
            half_q      <= '0;
            rx_q        <= '0;
            if (bad_cs) begin
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              err_q   <= 1'b0;
              cs_n_q  <= ~(NUM_CS'(1) << req_cs);
              state_q <= SETUP;
              // CPHA=0 presents the first bit before the first clock edge.
              if (!req_mode[0]) begin
                mosi_q <= ordered[DATA_W-1];
                tx_q   <= ordered << 1;
              end else begin
                tx_q   <= ordered;
              end
            end
          end
        end
        SETUP: begin
          if (tick) begin
            state_q <= XFER;
          end
        end
        XFER: begin
          if (tick) begin
            half_q <= half_q + HcW'(1);
            if (last_half) begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n_q  <= '1;
            state_q <= DONE;
          end
        end
        DONE: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_data_q  <= err_q ? '0 : (lsb_q ? bit_rev(rx_q) : rx_q);
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);
  assign spi_mosi  = mosi_q;
  assign spi_cs_n  = cs_n_q;

endmodule
